// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and defaults for the I/D-cache to cacheline-memory arbiter.
// Packaged as cache_arb_pkg so the arbiter and its grant picker agree on encodings.
package cache_arb_pkg;

  localparam int ADDR_W_DEF   = 32;
  localparam int LINE_W_DEF   = 256;
  localparam int OFFSET_W_DEF = 5;

  // Bit positions inside the 2-bit request / grant vectors.
  localparam int IDX_I = 0;
  localparam int IDX_D = 1;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_I,
    ARB_D,
    ARB_RELEASE
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } requester_t;

endpackage

// File: rtl/cache_mem_arbiter_rr_arb2.sv
// Combinational two-way grant picker: round-robin on ties, or D-cache wins ties
// when fixed_prio_i is set. Produces a one-hot (or all-zero) grant.
module rr_arb2
  import cache_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  requester_t last_grant_i,
  input  logic       fixed_prio_i,
  output logic [1:0] grant_o
);

  always_comb begin
    // NOTE: defaulting every always_comb output first prevents latch inference.
    grant_o = 2'b00;
    case (req_i)
      2'b01: grant_o = 2'b01;
      2'b10: grant_o = 2'b10;
      2'b11: begin
        // On a tie the side that did not win last time goes next.
        if (fixed_prio_i || (last_grant_i == REQ_I)) grant_o = 2'b10;
        else                                          grant_o = 2'b01;
      end
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the single cacheline memory port between the I-cache and D-cache
// miss paths, holding the winner's registered request until mem_resp.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LINE_W     = LINE_W_DEF,
  parameter int OFFSET_W   = OFFSET_W_DEF,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,

  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,

  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam logic [ADDR_W-1:0] LINE_MASK = {ADDR_W{1'b1}} << OFFSET_W;

  arb_state_t        state_q, state_d;
  requester_t        last_grant_q, last_grant_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;

  logic [1:0] req;
  logic [1:0] grant;

  assign req[IDX_I] = i_read;
  assign req[IDX_D] = d_read | d_write;

  rr_arb2 u_rr_arb2 (
    .req_i        (req),
    .last_grant_i (last_grant_q),
    .fixed_prio_i (FIXED_PRIO),
    .grant_o      (grant)
  );

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    i_rdata_d     = i_rdata_q;
    d_rdata_d     = d_rdata_q;
    i_resp        = 1'b0;
    d_resp        = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        if (grant[IDX_D]) begin
          // A write wins over a simultaneous read; that combination is illegal anyway.
          state_d       = ARB_D;
          last_grant_d  = REQ_D;
          mem_write_d   = d_write;
          mem_read_d    = ~d_write;
          mem_address_d = d_address & LINE_MASK;
          mem_wdata_d   = d_wdata;
        end else if (grant[IDX_I]) begin
          state_d       = ARB_I;
          last_grant_d  = REQ_I;
          mem_read_d    = 1'b1;
          mem_write_d   = 1'b0;
          mem_address_d = i_address & LINE_MASK;
        end
      end

      ARB_I: begin
        if (mem_resp) begin
          i_resp      = 1'b1;
          i_rdata_d   = mem_rdata;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = ARB_RELEASE;
        end
      end

      ARB_D: begin
        if (mem_resp) begin
          d_resp      = 1'b1;
          d_rdata_d   = mem_rdata;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = ARB_RELEASE;
        end
      end

      // One dead cycle lets the burst adaptor settle back to idle.
      ARB_RELEASE: state_d = ARB_IDLE;

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // NOTE: the wide line registers are reset too so the memory port and rdata never show X.
      state_q       <= ARB_IDLE;
      last_grant_q  <= REQ_I;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      i_rdata_q     <= '0;
      d_rdata_q     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      i_rdata_q     <= i_rdata_d;
      d_rdata_q     <= d_rdata_d;
    end
  end

  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;

  // The line is visible in the response cycle itself and held afterwards.
  assign i_rdata = i_resp ? mem_rdata : i_rdata_q;
  assign d_rdata = d_resp ? mem_rdata : d_rdata_q;

  a_d_op_exclusive: assert property (@(posedge clk) disable iff (!reset_n)
    !(d_read && d_write));

  a_resp_only_when_busy: assert property (@(posedge clk) disable iff (!reset_n)
    mem_resp |-> (state_q inside {ARB_I, ARB_D}));

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
Shares the single cacheline memory port (256-bit line, read/write/resp handshake, fronting the burst adaptor) between the I-cache and D-cache miss paths. It arbitrates between the two, registers the winner's request, and holds it on the memory port until the response. It then forces a one-cycle release gap so the adaptor returns to idle before the next grant. It sits between the two L1 caches and the cacheline adaptor.

Parameters:
ADDR_W, 32, address width
LINE_W, 256, cacheline width in bits
OFFSET_W, 5, line-offset bits cleared on mem_address (log2(LINE_W/8))
FIXED_PRIO, 0, 0 = round-robin between I and D; 1 = D-cache always wins ties

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
i_read  in  1  I-cache line read request, held until i_resp
i_address  in  ADDR_W  I-cache miss address
i_rdata  out  LINE_W  line returned to I-cache
i_resp  out  1  one-cycle done pulse to I-cache
d_read  in  1  D-cache line read request, held until d_resp
d_write  in  1  D-cache writeback request, held until d_resp
d_address  in  ADDR_W  D-cache miss/writeback address
d_wdata  in  LINE_W  D-cache writeback line
d_rdata  out  LINE_W  line returned to D-cache
d_resp  out  1  one-cycle done pulse to D-cache
mem_read  out  1  read request to adaptor
mem_write  out  1  write request to adaptor
mem_address  out  ADDR_W  line-aligned address to adaptor
mem_wdata  out  LINE_W  write line to adaptor
mem_rdata  in  LINE_W  read line from adaptor
mem_resp  in  1  one-cycle completion from adaptor

Behaviour:
- Reset is synchronous and active-low on clk. It overrides any state, including mid-transaction.
- Reset values: state=ARB_IDLE, mem_read=mem_write=0, mem_address=0, mem_wdata=0, i_resp=d_resp=0, last_grant=I.
- States: ARB_IDLE, ARB_I, ARB_D, ARB_RELEASE.
- ARB_IDLE: evaluate requests each cycle.
  - I-cache requests when i_read=1. D-cache requests when d_read|d_write=1.
  - Only one requesting: grant it.
  - Both requesting: FIXED_PRIO=1 grants D. FIXED_PRIO=0 grants the requester that is not last_grant.
  - On grant, register {addr & ~((1<<OFFSET_W)-1), wdata, op} into the mem_* output registers. Update last_grant. Go to ARB_I or ARB_D.
- ARB_I / ARB_D: mem_read or mem_write is held high from the cycle after the grant edge until mem_resp.
  - Address and data stay frozen even if the requester's inputs change.
- D op encoding: d_write=1 means write, regardless of d_read. d_read&d_write together is a protocol error: flag it with an assertion and treat it as a write.
- Response (cycle where mem_resp=1):
  - Granted requester's resp=1 combinationally in the same cycle.
  - Its rdata = mem_rdata. The ungranted rdata holds its last value.
  - The other requester's resp stays 0.
  - Next state is ARB_RELEASE; mem_read/mem_write clear at that edge.
- ARB_RELEASE: exactly one cycle with mem_read=mem_write=0. Always goes to ARB_IDLE; no arbitration happens in this cycle.
- Latency:
  - Request to mem_read/mem_write high: 1 cycle from idle.
  - mem_resp to requester resp: 0 cycles.
  - Minimum spacing between two grants: response cycle + 1 release cycle + 1 idle cycle.
- A request arriving during ARB_I/ARB_D/ARB_RELEASE waits. Requests are level-held, so none are lost.
- A granted requester that drops its request early is a protocol violation. The transaction still completes and resp still pulses.
- mem_resp while in ARB_IDLE or ARB_RELEASE is ignored (assertion fires). No resp is forwarded.
- Starvation: with FIXED_PRIO=0 and both requesters continuously active, grants alternate I, D, I, D.

Decomposition:
- Package cache_arb_pkg holds:
  - arb_state_t enum {ARB_IDLE, ARB_I, ARB_D, ARB_RELEASE}
  - requester_t enum {REQ_I, REQ_D}
  - LINE_W/OFFSET_W defaults
- One natural sub-module: rr_arb2. It is a combinational 2-way grant picker taking req[1:0], last_grant and fixed_prio, and producing a one-hot grant.
- The FSM and output registers live in the top module.

Test Plan:
- Single I read, i_address=0x0000_1234, mem_resp after 10 cycles with mem_rdata=0xA5.. -> mem_address=0x0000_1220, mem_read=1 only; i_resp pulses 1 cycle with i_rdata=0xA5..; d_resp=0.
- D writeback, d_address=0x8000_0040, d_wdata=0xDEAD.. -> mem_write=1, mem_wdata=0xDEAD.., mem_address=0x8000_0040; d_resp on mem_resp; mem_write=0 in the following cycle.
- Simultaneous i_read and d_read from reset, FIXED_PRIO=0 -> D granted first (last_grant=I), then I after the release cycle; 4 back-to-back pairs produce the grant order D,I,D,I.
- FIXED_PRIO=1, both requesting continuously for 3 transactions -> all 3 grants go to D; I is granted only after D drops.
- reset_n=0 asserted while in ARB_D with mem_write=1 -> next cycle mem_write=0, state ARB_IDLE, no resp pulses; a new i_read is then granted normally.
- Requester changes d_address to 0x1111_1100 mid-transaction -> mem_address stays at the originally latched value until mem_resp.
